// File: rtl/mem_stage_ctrl.sv
// M-stage pipeline register and data-memory handshake controller.
// Define MEM_SUBWORD_EN to enable lb/lbu/lh/lhu/sb/sh; otherwise those opcodes decode as NOPs.
module mem_stage_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr_E,
   input  logic        CMPrst_E,
   input  logic [1:0]  AddrLo_E,
   input  logic        mem_ack,
   output logic [31:0] Instr_M,
   output logic        CMPrst_M,
   output logic        mem_req,
   output logic        DM_WE,
   output logic [3:0]  ByteEn,
   output logic [2:0]  LoadType,
   output logic [4:0]  A3_M,
   output logic [1:0]  Tnew_M,
   output logic        Stall_M
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MEM_SUBWORD_EN
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_LH    = 6'b100001;
   localparam logic [5:0] OP_LHU   = 6'b100101;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_SH    = 6'b101001;
`endif
   localparam logic [5:0] F_ADDU   = 6'b100001;
   localparam logic [5:0] F_SUBU   = 6'b100011;
   localparam logic [5:0] F_MOVZ   = 6'b001010;

   typedef enum logic {IDLE, WAIT} state_t;

   function automatic logic [2:0] load_type(input logic [5:0] op);
      logic [2:0] lt;
      lt = 3'd0;
      case (op)
         OP_LW:   lt = 3'd1;
`ifdef MEM_SUBWORD_EN
         OP_LB:   lt = 3'd2;
         OP_LBU:  lt = 3'd3;
         OP_LH:   lt = 3'd4;
         OP_LHU:  lt = 3'd5;
`endif
         default: lt = 3'd0;
      endcase
      return lt;
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      logic st;
      st = 1'b0;
      case (op)
         OP_SW:   st = 1'b1;
`ifdef MEM_SUBWORD_EN
         OP_SB:   st = 1'b1;
         OP_SH:   st = 1'b1;
`endif
         default: st = 1'b0;
      endcase
      return st;
   endfunction

   function automatic logic misaligned(input logic [5:0] op, input logic [1:0] lo);
      logic mis;
      mis = 1'b0;
      case (op)
         OP_LW, OP_SW:         mis = (lo != 2'b00);
`ifdef MEM_SUBWORD_EN
         OP_LH, OP_LHU, OP_SH: mis = lo[0];
`endif
         default:              mis = 1'b0;
      endcase
      return mis;
   endfunction

   // An aligned, enabled load/store; everything else behaves as a NOP at this stage.
   function automatic logic valid_mem(input logic [5:0] op, input logic [1:0] lo);
      return ((load_type(op) != 3'd0) || is_store(op)) && !misaligned(op, lo);
   endfunction

   state_t     state;
   logic [1:0] addr_lo;
   logic       req_r;
   logic       we_r;
   logic [5:0] op_e;
   logic       mem_e;
   logic       load_e;
   logic       store_e;

   assign op_e    = Instr_E[31:26];
   assign mem_e   = valid_mem(op_e, AddrLo_E);
   assign load_e  = mem_e && (load_type(op_e) != 3'd0);
   assign store_e = mem_e && is_store(op_e);

   assign Stall_M = (state == WAIT) && !mem_ack;

   // Stage boundary E -> M; the ack edge both closes the access and admits the next instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         Instr_M  <= 32'd0;
         CMPrst_M <= 1'b0;
         addr_lo  <= 2'b00;
         Tnew_M   <= 2'd0;
         state    <= IDLE;
         req_r    <= 1'b0;
         we_r     <= 1'b0;
      end else if (!Stall_M) begin
         Instr_M  <= Instr_E;
         CMPrst_M <= CMPrst_E;
         addr_lo  <= AddrLo_E;
         if (load_e)
            Tnew_M <= 2'd1;
         else if (Tnew_M != 2'd0)
            Tnew_M <= Tnew_M - 2'd1;
         state    <= mem_e ? WAIT : IDLE;
         req_r    <= mem_e;
         we_r     <= store_e;
      end
   end

   assign mem_req = req_r;
   assign DM_WE   = we_r;

   logic [5:0] op_m;
   logic [5:0] funct_m;
   logic       mem_m;

   assign op_m    = Instr_M[31:26];
   assign funct_m = Instr_M[5:0];
   assign mem_m   = valid_mem(op_m, addr_lo);

   always_comb begin
      ByteEn = 4'b0000;
      if (mem_m) begin
         case (op_m)
            OP_SW:   ByteEn = 4'b1111;
`ifdef MEM_SUBWORD_EN
            OP_SH:   ByteEn = addr_lo[1] ? 4'b1100 : 4'b0011;
            OP_SB:   ByteEn = 4'b0001 << addr_lo;
`endif
            default: ByteEn = 4'b0000;
         endcase
      end
   end

   assign LoadType = mem_m ? load_type(op_m) : 3'd0;

   always_comb begin
      A3_M = 5'd0;
      case (op_m)
         OP_RTYPE: begin
            if (funct_m == F_ADDU || funct_m == F_SUBU)
               A3_M = Instr_M[15:11];
            else if (funct_m == F_MOVZ && CMPrst_M)
               A3_M = Instr_M[15:11];
         end
         OP_ORI, OP_LUI: A3_M = Instr_M[20:16];
         OP_JAL:         A3_M = 5'd31;
         default: begin
            if (mem_m && load_type(op_m) != 3'd0)
               A3_M = Instr_M[20:16];
         end
      endcase
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl; expectations follow whether MEM_SUBWORD_EN is defined.
module tb_mem_stage_ctrl;

   logic        clk;
   logic        reset;
   logic [31:0] Instr_E;
   logic        CMPrst_E;
   logic [1:0]  AddrLo_E;
   logic        mem_ack;
   logic [31:0] Instr_M;
   logic        CMPrst_M;
   logic        mem_req;
   logic        DM_WE;
   logic [3:0]  ByteEn;
   logic [2:0]  LoadType;
   logic [4:0]  A3_M;
   logic [1:0]  Tnew_M;
   logic        Stall_M;

   int checks = 0;
   int errors = 0;

   mem_stage_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .Instr_E  (Instr_E),
      .CMPrst_E (CMPrst_E),
      .AddrLo_E (AddrLo_E),
      .mem_ack  (mem_ack),
      .Instr_M  (Instr_M),
      .CMPrst_M (CMPrst_M),
      .mem_req  (mem_req),
      .DM_WE    (DM_WE),
      .ByteEn   (ByteEn),
      .LoadType (LoadType),
      .A3_M     (A3_M),
      .Tnew_M   (Tnew_M),
      .Stall_M  (Stall_M)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

   localparam logic [31:0] NOP     = 32'h0000_0000;
   localparam logic [31:0] LW_R5   = {6'b100011, 5'd1, 5'd5, 16'h0010};
   localparam logic [31:0] LW_R6   = {6'b100011, 5'd2, 5'd6, 16'h0020};
   localparam logic [31:0] SW_R3   = {6'b101011, 5'd1, 5'd3, 16'h0000};
   localparam logic [31:0] ADDU_R7 = {6'b000000, 5'd1, 5'd2, 5'd7, 5'd0, 6'b100001};
   localparam logic [31:0] MOVZ_R9 = {6'b000000, 5'd1, 5'd2, 5'd9, 5'd0, 6'b001010};
   localparam logic [31:0] JAL     = {6'b000011, 26'h0000123};
   localparam logic [31:0] ORI_R4  = {6'b001101, 5'd1, 5'd4, 16'h00ff};
   localparam logic [31:0] SB_R2   = {6'b101000, 5'd1, 5'd2, 16'h0002};
   localparam logic [31:0] SH_R2   = {6'b101001, 5'd1, 5'd2, 16'h0001};
   localparam logic [31:0] LB_R8   = {6'b100000, 5'd1, 5'd8, 16'h0000};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; Instr_E = LW_R5; CMPrst_E = 1'b1; AddrLo_E = 2'b00; mem_ack = 1'b0;
      step();
      chk("rst_instr", Instr_M, 32'd0);
      chk("rst_cmp", {31'd0, CMPrst_M}, 32'd0);
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_we", {31'd0, DM_WE}, 32'd0);
      chk("rst_be", {28'd0, ByteEn}, 32'd0);
      chk("rst_lt", {29'd0, LoadType}, 32'd0);
      chk("rst_a3", {27'd0, A3_M}, 32'd0);
      chk("rst_tnew", {30'd0, Tnew_M}, 32'd0);
      chk("rst_stall", {31'd0, Stall_M}, 32'd0);

      // lw, ack arrives in the third WAIT cycle
      reset = 1'b0; CMPrst_E = 1'b0;
      step();
      chk("lw_req1", {31'd0, mem_req}, 32'd1);
      chk("lw_stall1", {31'd0, Stall_M}, 32'd1);
      chk("lw_lt", {29'd0, LoadType}, 32'd1);
      chk("lw_a3", {27'd0, A3_M}, 32'd5);
      chk("lw_tnew", {30'd0, Tnew_M}, 32'd1);
      chk("lw_be", {28'd0, ByteEn}, 32'd0);
      chk("lw_we", {31'd0, DM_WE}, 32'd0);
      Instr_E = NOP;
      step();
      chk("lw_req2", {31'd0, mem_req}, 32'd1);
      chk("lw_stall2", {31'd0, Stall_M}, 32'd1);
      chk("lw_hold", Instr_M, LW_R5);
      chk("lw_tnew_hold", {30'd0, Tnew_M}, 32'd1);
      step();
      mem_ack = 1'b1;
      #1;
      chk("lw_req3", {31'd0, mem_req}, 32'd1);
      chk("lw_stall3", {31'd0, Stall_M}, 32'd0);
      step();
      mem_ack = 1'b0;
      chk("lw_done_req", {31'd0, mem_req}, 32'd0);
      chk("lw_done_instr", Instr_M, NOP);
      chk("lw_done_tnew", {30'd0, Tnew_M}, 32'd0);
      chk("lw_done_lt", {29'd0, LoadType}, 32'd0);

      // destination-register decode for non-memory instructions
      Instr_E = ADDU_R7;
      step();
      chk("addu_a3", {27'd0, A3_M}, 32'd7);
      chk("addu_req", {31'd0, mem_req}, 32'd0);
      Instr_E = MOVZ_R9; CMPrst_E = 1'b0;
      step();
      chk("movz0_a3", {27'd0, A3_M}, 32'd0);
      CMPrst_E = 1'b1;
      step();
      chk("movz1_a3", {27'd0, A3_M}, 32'd9);
      chk("movz1_cmp", {31'd0, CMPrst_M}, 32'd1);
      Instr_E = JAL; CMPrst_E = 1'b0;
      step();
      chk("jal_a3", {27'd0, A3_M}, 32'd31);
      Instr_E = ORI_R4;
      step();
      chk("ori_a3", {27'd0, A3_M}, 32'd4);

      // misaligned lw is a NOP
      Instr_E = LW_R5; AddrLo_E = 2'b01;
      step();
      chk("lwmis_req", {31'd0, mem_req}, 32'd0);
      chk("lwmis_lt", {29'd0, LoadType}, 32'd0);
      chk("lwmis_a3", {27'd0, A3_M}, 32'd0);
      chk("lwmis_tnew", {30'd0, Tnew_M}, 32'd0);
      chk("lwmis_stall", {31'd0, Stall_M}, 32'd0);

      // sb at offset 2 with immediate ack
      Instr_E = SB_R2; AddrLo_E = 2'b10;
      step();
      Instr_E = NOP; AddrLo_E = 2'b00; mem_ack = 1'b1;
      #1;
`ifdef MEM_SUBWORD_EN
      chk("sb_req", {31'd0, mem_req}, 32'd1);
      chk("sb_we", {31'd0, DM_WE}, 32'd1);
      chk("sb_be", {28'd0, ByteEn}, 32'h4);
`else
      chk("sb_req", {31'd0, mem_req}, 32'd0);
      chk("sb_we", {31'd0, DM_WE}, 32'd0);
      chk("sb_be", {28'd0, ByteEn}, 32'h0);
`endif
      chk("sb_stall", {31'd0, Stall_M}, 32'd0);
      step();
      chk("sb_after_we", {31'd0, DM_WE}, 32'd0);
      chk("sb_after_req", {31'd0, mem_req}, 32'd0);
      chk("idle_ack_ignored", {31'd0, Stall_M}, 32'd0);
      mem_ack = 1'b0;

      // misaligned sh is a NOP
      Instr_E = SH_R2; AddrLo_E = 2'b01;
      step();
      chk("shmis_req", {31'd0, mem_req}, 32'd0);
      chk("shmis_be", {28'd0, ByteEn}, 32'd0);
      chk("shmis_a3", {27'd0, A3_M}, 32'd0);
      chk("shmis_stall", {31'd0, Stall_M}, 32'd0);

      // sw then lw, ack on the sw's first WAIT cycle
      Instr_E = SW_R3; AddrLo_E = 2'b00;
      step();
      chk("sw_req", {31'd0, mem_req}, 32'd1);
      chk("sw_we", {31'd0, DM_WE}, 32'd1);
      chk("sw_be", {28'd0, ByteEn}, 32'hf);
      chk("sw_stall", {31'd0, Stall_M}, 32'd1);
      chk("sw_a3", {27'd0, A3_M}, 32'd0);
      Instr_E = LW_R6; mem_ack = 1'b1;
      #1;
      chk("sw_ack_stall", {31'd0, Stall_M}, 32'd0);
      step();
      mem_ack = 1'b0; Instr_E = NOP;
      #1;
      chk("b2b_req", {31'd0, mem_req}, 32'd1);
      chk("b2b_we", {31'd0, DM_WE}, 32'd0);
      chk("b2b_be", {28'd0, ByteEn}, 32'h0);
      chk("b2b_instr", Instr_M, LW_R6);
      chk("b2b_lt", {29'd0, LoadType}, 32'd1);
      chk("b2b_a3", {27'd0, A3_M}, 32'd6);
      chk("b2b_stall", {31'd0, Stall_M}, 32'd1);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("b2b_done_req", {31'd0, mem_req}, 32'd0);

      // reset during a store's WAIT aborts it
      Instr_E = SW_R3;
      step();
      chk("rstw_req_pre", {31'd0, mem_req}, 32'd1);
      reset = 1'b1;
      step();
      chk("rstw_instr", Instr_M, 32'd0);
      chk("rstw_req", {31'd0, mem_req}, 32'd0);
      chk("rstw_we", {31'd0, DM_WE}, 32'd0);
      chk("rstw_stall", {31'd0, Stall_M}, 32'd0);
      reset = 1'b0; Instr_E = NOP;
      step();
      chk("rstw_idle_req", {31'd0, mem_req}, 32'd0);

      // lb latched
      Instr_E = LB_R8; AddrLo_E = 2'b00;
      step();
      chk("lb_instr", Instr_M, LB_R8);
`ifdef MEM_SUBWORD_EN
      chk("lb_lt", {29'd0, LoadType}, 32'd2);
      chk("lb_req", {31'd0, mem_req}, 32'd1);
      chk("lb_a3", {27'd0, A3_M}, 32'd8);
      chk("lb_tnew", {30'd0, Tnew_M}, 32'd1);
      Instr_E = NOP; mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
`else
      chk("lb_lt", {29'd0, LoadType}, 32'd0);
      chk("lb_req", {31'd0, mem_req}, 32'd0);
      chk("lb_a3", {27'd0, A3_M}, 32'd0);
      chk("lb_tnew", {30'd0, Tnew_M}, 32'd0);
      Instr_E = NOP;
      step();
`endif
      chk("end_req", {31'd0, mem_req}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
